// File: rtl/tradeoff_w_loader.sv
// Feeds the tradeoff solver: assembles W from a byte stream, waits for found,
// and returns the captured N (or a timeout marker) over a valid/ready result port.
module tradeoff_w_loader #(
  parameter int W_BITS  = 69,
  parameter int N_BITS  = 53,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [W_BITS-1:0] w_out,
  input  logic              found_in,
  input  logic [N_BITS-1:0] n_in,
  output logic [N_BITS-1:0] res_data,
  output logic              res_timeout,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; the sender holds data stable until that edge.
  localparam int NBYTES = (W_BITS + 7) / 8;
  localparam int IDX_W  = $clog2(NBYTES);
  localparam int CNT_W  = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_COLLECT, S_SETTLE, S_WAIT, S_RESULT} state_t;

  state_t             state;
  logic [IDX_W-1:0]   byte_idx;
  logic [CNT_W-1:0]   cnt;
  logic [W_BITS-1:0]  w_next;

  // Overlay the incoming byte on its lane; bits beyond W_BITS are dropped.
  always_comb begin
    w_next = w_out;
    for (int i = 0; i < W_BITS; i++) begin
      if (byte_idx == IDX_W'(i / 8)) w_next[i] = in_data[i % 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_COLLECT;
      byte_idx    <= '0;
      cnt         <= '0;
      w_out       <= '0;
      res_data    <= '0;
      res_timeout <= 1'b0;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
      in_ready    <= 1'b1;
    end else begin
      case (state)
        S_COLLECT: begin
          if (in_valid && in_ready) begin
            w_out <= w_next;
            if (byte_idx == IDX_W'(NBYTES - 1)) begin
              state    <= S_SETTLE;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              cnt      <= '0;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        // found may still reflect the previous W here, so it is not looked at.
        S_SETTLE: begin
          if (cnt == CNT_W'(SETTLE - 1)) begin
            state <= S_WAIT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (found_in) begin
            res_data    <= n_in;
            res_timeout <= 1'b0;
            res_valid   <= 1'b1;
            busy        <= 1'b0;
            state       <= S_RESULT;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            res_data    <= '0;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            busy        <= 1'b0;
            state       <= S_RESULT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESULT: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            byte_idx  <= '0;
            in_ready  <= 1'b1;
            state     <= S_COLLECT;
          end
        end
        default: state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_tradeoff_w_loader.sv
// Directed bench for tradeoff_w_loader: results are checked by a queue-based
// scoreboard, control timing by inline checks from the stimulus thread.
module tb_tradeoff_w_loader;

  localparam int W_BITS  = 69;
  localparam int N_BITS  = 53;
  localparam int TIMEOUT = 1024;

  logic              clk;
  logic              rst;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [W_BITS-1:0] w_out;
  logic              found_in;
  logic [N_BITS-1:0] n_in;
  logic [N_BITS-1:0] res_data;
  logic              res_timeout;
  logic              res_valid;
  logic              res_ready;
  logic              busy;

  logic [N_BITS:0]   exp_q[$];
  logic [N_BITS:0]   mon_exp;
  int                n_checks = 0;
  int                n_fail   = 0;

  tradeoff_w_loader #(.W_BITS(W_BITS), .N_BITS(N_BITS), .SETTLE(2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .w_out(w_out), .found_in(found_in), .n_in(n_in), .res_data(res_data),
    .res_timeout(res_timeout), .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish, required finish before 3 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // monitor: every completed result handshake is compared against the queue head
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL result_unexpected: got %0h, required no result", {res_timeout, res_data});
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", {res_timeout, res_data}, mon_exp);
      end
    end
  end

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int tries = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && tries < 100) begin
      @(negedge clk);
      tries++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_accept: got in_ready=0 for 100 cycles, required 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [71:0] w);
    for (int k = 0; k < 9; k++) send_byte(w[8*k +: 8]);
  endtask

  logic [71:0]       w_bp;
  logic [71:0]       w_rst;
  logic [N_BITS-1:0] bp_n;

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; found_in = 1'b0; n_in = '0; res_ready = 1'b1;
    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_w_out", w_out, '0);
    check("rst_res_data", {res_timeout, res_data}, '0);
    @(negedge clk); rst = 1'b0;
    wait_cycles(1);

    // nominal: all-ones W, found 5 cycles into WAIT
    n_in = 53'd4503599627370495;
    exp_q.push_back({1'b0, 53'd4503599627370495});
    send_word({8'h1F, {8{8'hFF}}});
    check("nom_w_out", w_out, {W_BITS{1'b1}});
    check("nom_busy_settle", {busy, in_ready}, 2'b10);
    wait_cycles(2);
    wait_cycles(5);
    found_in = 1'b1;
    check("nom_valid_before", res_valid, 1'b0);
    wait_cycles(1);
    check("nom_valid_after", {res_valid, busy}, 2'b10);
    wait_cycles(1);

    // stale found: held high through COLLECT and SETTLE
    n_in = 53'h0_A5A5_A5A5_A5A5;
    exp_q.push_back({1'b0, 53'h0_A5A5_A5A5_A5A5});
    send_word(72'h09_0807_0605_0403_0201);
    check("stale_w_out", w_out, 69'h09_0807_0605_0403_0201);
    check("stale_settle0", res_valid, 1'b0);
    wait_cycles(1);
    check("stale_settle1", res_valid, 1'b0);
    wait_cycles(1);
    check("stale_wait0", res_valid, 1'b0);
    wait_cycles(1);
    check("stale_capture", res_valid, 1'b1);
    found_in = 1'b0;
    wait_cycles(1);

    // top-byte masking
    n_in = 53'h123;
    exp_q.push_back({1'b0, 53'h123});
    send_word({8'hE3, 64'h0});
    check("mask_w_out", w_out, {5'b00011, 64'h0});
    wait_cycles(5);
    found_in = 1'b1;
    wait_cycles(1);
    found_in = 1'b0;
    check("mask_valid", res_valid, 1'b1);
    wait_cycles(1);

    // timeout: found never arrives
    exp_q.push_back({1'b1, {N_BITS{1'b0}}});
    send_word(72'h11_2233_4455_6677_8899);
    wait_cycles(2);
    wait_cycles(TIMEOUT - 1);
    check("to_valid_before", res_valid, 1'b0);
    wait_cycles(1);
    check("to_result", {res_valid, res_timeout, res_data}, {2'b11, {N_BITS{1'b0}}});
    wait_cycles(1);

    // found on the last WAIT cycle wins over timeout
    n_in = 53'h1_2345_6789_ABCD;
    exp_q.push_back({1'b0, 53'h1_2345_6789_ABCD});
    send_word(72'h01_0000_0000_0000_0001);
    wait_cycles(2);
    wait_cycles(TIMEOUT - 1);
    found_in = 1'b1;
    check("late_valid_before", res_valid, 1'b0);
    wait_cycles(1);
    found_in = 1'b0;
    check("late_result", {res_valid, res_timeout}, 2'b10);
    wait_cycles(1);

    // backpressure: result held for 10 cycles, upstream byte not consumed
    res_ready = 1'b0;
    bp_n = 53'h0_DEAD_BEEF_0042;
    n_in = bp_n;
    exp_q.push_back({1'b0, 53'h0_DEAD_BEEF_0042});
    w_bp = 72'h15_F0E1_D2C3_B4A5_9687;
    send_word(w_bp);
    wait_cycles(2);
    found_in = 1'b1;
    wait_cycles(1);
    found_in = 1'b0;
    n_in = '0;
    in_data = 8'h5C;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      wait_cycles(1);
      check("bp_hold", {res_valid, in_ready, res_timeout, res_data}, {3'b100, bp_n});
      check("bp_w_held", w_out, w_bp[W_BITS-1:0]);
    end
    res_ready = 1'b1;
    wait_cycles(1);
    check("bp_release", {res_valid, in_ready}, 2'b01);
    wait_cycles(1);
    in_valid = 1'b0;
    check("bp_byte0", w_out, {w_bp[W_BITS-1:8], 8'h5C});

    // reset mid-WAIT, then a fresh word from byte 0
    for (int k = 1; k < 9; k++) send_byte(8'h40 + 8'(k));
    wait_cycles(4);
    check("pre_rst_busy", busy, 1'b1);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_state", {res_valid, busy, in_ready}, 3'b001);
    check("mid_rst_w_out", w_out, '0);
    @(negedge clk); rst = 1'b0;
    wait_cycles(1);
    n_in = 53'h0_0000_0000_7777;
    exp_q.push_back({1'b0, 53'h0_0000_0000_7777});
    w_rst = 72'h0A_1B2C_3D4E_5F60_7182;
    send_word(w_rst);
    check("post_rst_w_out", w_out, w_rst[W_BITS-1:0]);
    wait_cycles(2);
    found_in = 1'b1;
    wait_cycles(1);
    found_in = 1'b0;
    wait_cycles(3);

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tradeoff_w_loader.md
Name: tradeoff_w_loader

Overview:
- Upstream feeder and result capture stage for the 52-bit tradeoff solver.
- Assembles the solver's 69-bit W operand from an 8-bit valid/ready byte stream and holds W stable while the solver runs.
- Waits for the solver's found level, captures its 53-bit N, and returns N downstream over a valid/ready result port, with a timeout guard.

Parameters:
- W_BITS, 69, width of solver operand W.
- N_BITS, 53, width of solver result N.
- SETTLE, 2, cycles after W update during which found is ignored (min 1).
- TIMEOUT, 1024, max cycles waiting for found before aborting (min 4).

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous active-high reset.
- in_data  in  8  W byte, least-significant byte first.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts byte (high only in COLLECT).
- w_out  out  W_BITS  operand to solver W input; registered.
- found_in  in  1  solver found level.
- n_in  in  N_BITS  solver N output.
- res_data  out  N_BITS  captured N (0 on timeout).
- res_timeout  out  1  result was produced by timeout.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts result.
- busy  out  1  high in SETTLE and WAIT.

Behaviour:
- Reset, asynchronous and active-high, drives: state=COLLECT, byte index=0, w_out=0, res_data=0, res_timeout=0, res_valid=0, busy=0, in_ready=1, counters=0.
- Byte count: ceil(W_BITS/8)=9. Byte k loads w_out[8k+7:8k] when in_valid&&in_ready. Byte 8 contributes only bits [4:0] to w_out[68:64]; in_data[7:5] of that byte are discarded.
- w_out updates in place byte by byte. The solver sees partial words during COLLECT; this is harmless because found is gated by state.
- COLLECT: in_ready=1. On accepting byte 8, go to SETTLE and clear the cycle counter. No byte is accepted on the cycle of the transition.
- SETTLE: in_ready=0, busy=1. found_in is ignored, even if high from the previous W. After SETTLE cycles, go to WAIT and clear the cycle counter.
- WAIT: in_ready=0, busy=1. The counter increments every cycle.
  - First cycle with found_in==1: capture res_data<=n_in, res_timeout<=0, res_valid<=1 on the next edge, then go to RESULT.
  - If the counter reaches TIMEOUT-1 with found_in still 0: res_data<=0, res_timeout<=1, res_valid<=1, go to RESULT.
  - If found_in==1 on the same cycle the counter hits TIMEOUT-1, found wins (res_timeout=0).
- RESULT: res_valid held, and res_data/res_timeout held stable, until res_ready. On res_valid&&res_ready: res_valid<=0, byte index<=0, go to COLLECT.
- w_out holds its value through RESULT and into the next COLLECT until byte 0 of the next word overwrites it.
- Latency: last byte accepted at edge t gives WAIT entry at t+SETTLE. found high at cycle f in WAIT gives res_valid=1 at edge f+1.
- Reset mid-operation (any state): immediate return to reset values. A partially collected word is discarded and a pending result is lost.
- in_valid while in_ready=0 is ignored; the byte is not consumed, so the upstream holds it.
- Counters are sized to clog2(TIMEOUT)+1 bits and never wrap.

Test Plan:
- Reset: assert rst asynchronously mid-WAIT -> same instant: res_valid=0, busy=0, in_ready=1, w_out=0; next word collects from byte 0.
- Nominal: stream bytes FF×8 then 1F (W=2^69-1), solver model raises found 5 cycles into WAIT with n_in=4503599627370495 -> res_data=4503599627370495, res_timeout=0, res_valid one edge after found.
- Top-byte masking: byte 8 = 0xE3 with bytes 0..7 = 0 -> w_out = 3<<64; bits [7:5] discarded.
- Stale found: found_in held 1 from previous word through SETTLE -> ignored during SETTLE; capture occurs on the first WAIT cycle only.
- Timeout: found_in held 0 -> exactly TIMEOUT (1024) cycles in WAIT, then res_valid=1, res_timeout=1, res_data=0; found on cycle 1023 instead -> res_timeout=0.
- Backpressure: res_ready=0 for 10 cycles -> res_valid and res_data stable, in_ready=0, new in_valid bytes not consumed; res_ready=1 -> handshake, in_ready=1 on the next cycle.
